// File: rtl/lsu_dmem_master_if.sv
// Core-side request/response channel and DMEM responder port of the load/store unit.
// The master modport is the LSU's view; slave is the view of its core/DMEM environment.
`timescale 1ns/1ps
interface lsu_dmem_master_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;

  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  logic [31:0] dmem_addr;
  logic [31:0] dmem_wdata;
  logic [3:0]  dmem_we;
  logic        dmem_rd;
  logic [2:0]  dmem_load_select;
  logic [31:0] dmem_rdata;

  modport master (
    input  req_valid, req_we, req_funct3, req_addr, req_wdata, rsp_ready, dmem_rdata,
    output req_ready, rsp_valid, rsp_rdata, rsp_err,
           dmem_addr, dmem_wdata, dmem_we, dmem_rd, dmem_load_select
  );

  modport slave (
    output req_valid, req_we, req_funct3, req_addr, req_wdata, rsp_ready, dmem_rdata,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err,
           dmem_addr, dmem_wdata, dmem_we, dmem_rd, dmem_load_select
  );
endinterface

// File: rtl/lsu_dmem_master.sv
// Load/store initiator: one request at a time, word-aligned DMEM access with byte lanes,
// sign/zero-extended load data and a registered response carrying an error flag.
`timescale 1ns/1ps
module lsu_dmem_master #(
  parameter int unsigned READ_LATENCY = 1  // dmem_rd to dmem_rdata valid, legal 1..4
) (
  input logic            clk,
  input logic            rstn,
  lsu_dmem_master_if.master bus
);

  typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_WAIT, S_RESP} state_t;

  localparam logic [1:0] WAIT_LAST = 2'(READ_LATENCY - 1);

  state_t      state_q, state_d;
  logic        we_q, we_d;
  logic [2:0]  funct3_q, funct3_d;
  logic [1:0]  addr_lo_q, addr_lo_d;
  logic [1:0]  wait_cnt_q, wait_cnt_d;
  logic [31:0] dmem_addr_q, dmem_addr_d;
  logic [31:0] dmem_wdata_q, dmem_wdata_d;
  logic [3:0]  dmem_we_q, dmem_we_d;
  logic        dmem_rd_q, dmem_rd_d;
  logic        rsp_valid_q, rsp_valid_d;
  logic [31:0] rsp_rdata_q, rsp_rdata_d;
  logic        rsp_err_q, rsp_err_d;

  // Request decode, evaluated on the incoming request so it is ready at the accept edge.
  logic        req_illegal, req_misaligned;
  logic [3:0]  req_mask;
  logic [31:0] req_store_data;

  // NOTE: every variable written in always_comb gets a default first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    req_illegal = 1'b0;
    if (bus.req_we) req_illegal = (bus.req_funct3 > 3'b010);
    else            req_illegal = (bus.req_funct3 == 3'b011) || (bus.req_funct3[2:1] == 2'b11);

    req_misaligned = 1'b0;
    case (bus.req_funct3[1:0])
      2'b01:   req_misaligned = bus.req_addr[0];
      2'b10:   req_misaligned = (bus.req_addr[1:0] != 2'b00);
      default: req_misaligned = 1'b0;
    endcase

    req_mask       = 4'b1111;
    req_store_data = bus.req_wdata;
    case (bus.req_funct3[1:0])
      2'b00: begin
        req_mask       = 4'b0001 << bus.req_addr[1:0];
        req_store_data = {4{bus.req_wdata[7:0]}};
      end
      2'b01: begin
        req_mask       = 4'b0011 << {bus.req_addr[1], 1'b0};
        req_store_data = {2{bus.req_wdata[15:0]}};
      end
      default: ;
    endcase
  end

  // Lane extraction from the full word DMEM returns, using the latched low address bits.
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic [31:0] ld_data;

  always_comb begin
    ld_byte = bus.dmem_rdata[{addr_lo_q, 3'b000} +: 8];
    ld_half = bus.dmem_rdata[{addr_lo_q[1], 4'b0000} +: 16];
    case (funct3_q)
      3'b000:  ld_data = {{24{ld_byte[7]}}, ld_byte};
      3'b001:  ld_data = {{16{ld_half[15]}}, ld_half};
      3'b100:  ld_data = {24'h0, ld_byte};
      3'b101:  ld_data = {16'h0, ld_half};
      default: ld_data = bus.dmem_rdata;
    endcase
  end

  always_comb begin
    state_d      = state_q;
    we_d         = we_q;
    funct3_d     = funct3_q;
    addr_lo_d    = addr_lo_q;
    wait_cnt_d   = wait_cnt_q;
    dmem_addr_d  = dmem_addr_q;
    dmem_wdata_d = dmem_wdata_q;
    dmem_we_d    = 4'b0000;  // write strobe lives for exactly the ACCESS cycle
    dmem_rd_d    = dmem_rd_q;
    rsp_valid_d  = rsp_valid_q;
    rsp_rdata_d  = rsp_rdata_q;
    rsp_err_d    = rsp_err_q;

    case (state_q)
      S_IDLE: begin
        if (bus.req_valid) begin
          we_d      = bus.req_we;
          funct3_d  = bus.req_funct3;
          addr_lo_d = bus.req_addr[1:0];
          if (req_illegal || req_misaligned) begin
            state_d     = S_RESP;
            rsp_valid_d = 1'b1;
            rsp_err_d   = 1'b1;
            rsp_rdata_d = 32'h0;
          end else begin
            state_d      = S_ACCESS;
            dmem_addr_d  = {bus.req_addr[31:2], 2'b00};
            dmem_wdata_d = req_store_data;
            if (bus.req_we) dmem_we_d = req_mask;
            else            dmem_rd_d = 1'b1;
          end
        end
      end
      S_ACCESS: begin
        if (we_q) begin
          state_d     = S_RESP;
          rsp_valid_d = 1'b1;
          rsp_err_d   = 1'b0;
          rsp_rdata_d = 32'h0;
        end else begin
          state_d    = S_WAIT;
          wait_cnt_d = WAIT_LAST;
        end
      end
      S_WAIT: begin
        if (wait_cnt_q == 2'd0) begin
          state_d     = S_RESP;
          dmem_rd_d   = 1'b0;
          rsp_valid_d = 1'b1;
          rsp_err_d   = 1'b0;
          rsp_rdata_d = ld_data;
        end else begin
          wait_cnt_d = wait_cnt_q - 2'd1;
        end
      end
      S_RESP: begin
        if (bus.rsp_ready) begin
          state_d     = S_IDLE;
          rsp_valid_d = 1'b0;
          rsp_err_d   = 1'b0;
          rsp_rdata_d = 32'h0;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: state uses non-blocking assignments only; the async reset clears every register so
  // dmem_we/dmem_rd drop the moment rstn falls, independent of the clock.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q      <= S_IDLE;
      we_q         <= 1'b0;
      funct3_q     <= 3'b000;
      addr_lo_q    <= 2'b00;
      wait_cnt_q   <= 2'b00;
      dmem_addr_q  <= 32'h0;
      dmem_wdata_q <= 32'h0;
      dmem_we_q    <= 4'b0000;
      dmem_rd_q    <= 1'b0;
      rsp_valid_q  <= 1'b0;
      rsp_rdata_q  <= 32'h0;
      rsp_err_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      we_q         <= we_d;
      funct3_q     <= funct3_d;
      addr_lo_q    <= addr_lo_d;
      wait_cnt_q   <= wait_cnt_d;
      dmem_addr_q  <= dmem_addr_d;
      dmem_wdata_q <= dmem_wdata_d;
      dmem_we_q    <= dmem_we_d;
      dmem_rd_q    <= dmem_rd_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_rdata_q  <= rsp_rdata_d;
      rsp_err_q    <= rsp_err_d;
    end
  end

  assign bus.req_ready        = (state_q == S_IDLE);
  assign bus.rsp_valid        = rsp_valid_q;
  assign bus.rsp_rdata        = rsp_rdata_q;
  assign bus.rsp_err          = rsp_err_q;
  assign bus.dmem_addr        = dmem_addr_q;
  assign bus.dmem_wdata       = dmem_wdata_q;
  assign bus.dmem_we          = dmem_we_q;
  assign bus.dmem_rd          = dmem_rd_q;
  assign bus.dmem_load_select = 3'b010;

endmodule

// File: tb/tb_lsu_dmem_master.sv
// Directed bench for lsu_dmem_master: one DUT at READ_LATENCY=1 against a small DMEM model,
// a second at READ_LATENCY=3 for the latency check on the ID register.
`timescale 1ns/1ps
module tb_lsu_dmem_master;

  logic clk = 1'b0;
  logic rstn;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  lsu_dmem_master_if if0 ();
  lsu_dmem_master_if if1 ();

  lsu_dmem_master #(.READ_LATENCY(1)) dut0 (.clk(clk), .rstn(rstn), .bus(if0));
  lsu_dmem_master #(.READ_LATENCY(3)) dut1 (.clk(clk), .rstn(rstn), .bus(if1));

  // DMEM model: 16 RAM words at 0x8000_0000 plus the read-only ID register at 0x0010_0000.
  logic [31:0] ram [16] = '{default: 32'h0};

  function automatic logic [31:0] lookup(input logic [31:0] a);
    if (a == 32'h0010_0000) return 32'h1329_6397;
    if (a[31:28] == 4'h8)   return ram[a[5:2]];
    return 32'h0;
  endfunction

  always @(posedge clk) begin
    if (if0.dmem_we != 4'b0000 && if0.dmem_addr[31:28] == 4'h8)
      for (int i = 0; i < 4; i++)
        if (if0.dmem_we[i]) ram[if0.dmem_addr[5:2]][i*8 +: 8] <= if0.dmem_wdata[i*8 +: 8];
  end

  logic [31:0] rdata0;
  logic [31:0] pipe1 [3];
  always @(posedge clk) begin
    rdata0   <= if0.dmem_rd ? lookup(if0.dmem_addr) : 32'h0;
    pipe1[0] <= if1.dmem_rd ? lookup(if1.dmem_addr) : 32'h0;
    pipe1[1] <= pipe1[0];
    pipe1[2] <= pipe1[1];
  end
  assign if0.dmem_rdata = rdata0;
  assign if1.dmem_rdata = pipe1[2];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Present one request on if0; returns #1 after the accept edge.
  task automatic send(input logic we, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] wd);
    check("req_ready_idle", 32'(if0.req_ready), 32'h1);
    if0.req_valid  = 1'b1;
    if0.req_we     = we;
    if0.req_funct3 = f3;
    if0.req_addr   = a;
    if0.req_wdata  = wd;
    @(posedge clk); #1;
    if0.req_valid  = 1'b0;
  endtask

  // Count edges after acceptance until rsp_valid, bounded.
  task automatic wait_rsp(input string tag, input int exp_edges);
    int n = 0;
    while (!if0.rsp_valid && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    check({tag, "_latency"}, 32'(n), 32'(exp_edges));
  endtask

  task automatic finish_rsp(input string tag, input logic [31:0] exp_rdata, input logic exp_err);
    check({tag, "_rdata"}, if0.rsp_rdata, exp_rdata);
    check({tag, "_err"}, 32'(if0.rsp_err), 32'(exp_err));
    if0.rsp_ready = 1'b1;
    @(posedge clk); #1;
    if0.rsp_ready = 1'b0;
    check({tag, "_valid_drop"}, 32'(if0.rsp_valid), 32'h0);
    check({tag, "_back_idle"}, 32'(if0.req_ready), 32'h1);
  endtask

  initial begin
    rstn = 1'b0;
    if0.req_valid = 1'b0; if0.req_we = 1'b0; if0.req_funct3 = 3'b000;
    if0.req_addr = 32'h0; if0.req_wdata = 32'h0; if0.rsp_ready = 1'b0;
    if1.req_valid = 1'b0; if1.req_we = 1'b0; if1.req_funct3 = 3'b000;
    if1.req_addr = 32'h0; if1.req_wdata = 32'h0; if1.rsp_ready = 1'b0;
    #12;
    check("rst_req_ready", 32'(if0.req_ready), 32'h1);
    check("rst_rsp_valid", 32'(if0.rsp_valid), 32'h0);
    check("rst_rsp_rdata", if0.rsp_rdata, 32'h0);
    check("rst_dmem_we", 32'(if0.dmem_we), 32'h0);
    check("rst_dmem_rd", 32'(if0.dmem_rd), 32'h0);
    check("rst_dmem_addr", if0.dmem_addr, 32'h0);
    check("rst_load_select", 32'(if0.dmem_load_select), 32'h2);
    @(posedge clk); #1;
    rstn = 1'b1;
    @(posedge clk); #1;

    // SW then LW of the same word
    send(1'b1, 3'b010, 32'h8000_0010, 32'hFEDC_BA98);
    check("sw_we", 32'(if0.dmem_we), 32'hF);
    check("sw_addr", if0.dmem_addr, 32'h8000_0010);
    check("sw_wdata", if0.dmem_wdata, 32'hFEDC_BA98);
    wait_rsp("sw", 1);
    check("sw_we_one_cycle", 32'(if0.dmem_we), 32'h0);
    finish_rsp("sw", 32'h0, 1'b0);
    check("sw_ram", ram[4], 32'hFEDC_BA98);

    send(1'b0, 3'b010, 32'h8000_0010, 32'h0);
    check("lw_rd", 32'(if0.dmem_rd), 32'h1);
    wait_rsp("lw", 2);
    check("lw_rd_drop", 32'(if0.dmem_rd), 32'h0);
    finish_rsp("lw", 32'hFEDC_BA98, 1'b0);

    // SB into lane 1, then LB / LBU of that byte
    send(1'b1, 3'b000, 32'h8000_0011, 32'h0000_00A5);
    check("sb_addr", if0.dmem_addr, 32'h8000_0010);
    check("sb_we", 32'(if0.dmem_we), 32'h2);
    check("sb_wdata", if0.dmem_wdata, 32'hA5A5_A5A5);
    wait_rsp("sb", 1);
    finish_rsp("sb", 32'h0, 1'b0);
    check("sb_ram", ram[4], 32'hFEDC_A598);

    send(1'b0, 3'b000, 32'h8000_0011, 32'h0);
    wait_rsp("lb", 2);
    finish_rsp("lb", 32'hFFFF_FFA5, 1'b0);

    send(1'b0, 3'b100, 32'h8000_0011, 32'h0);
    wait_rsp("lbu", 2);
    finish_rsp("lbu", 32'h0000_00A5, 1'b0);

    // Upper half: LH sign-extends, LHU zero-extends
    send(1'b0, 3'b001, 32'h8000_0012, 32'h0);
    wait_rsp("lh", 2);
    finish_rsp("lh", 32'hFFFF_FEDC, 1'b0);

    send(1'b0, 3'b101, 32'h8000_0012, 32'h0);
    wait_rsp("lhu", 2);
    finish_rsp("lhu", 32'h0000_FEDC, 1'b0);

    // SH into the upper half of word 5
    send(1'b1, 3'b001, 32'h8000_0016, 32'hFFFF_1234);
    check("sh_we", 32'(if0.dmem_we), 32'hC);
    check("sh_wdata", if0.dmem_wdata, 32'h1234_1234);
    wait_rsp("sh", 1);
    finish_rsp("sh", 32'h0, 1'b0);
    check("sh_ram", ram[5], 32'h1234_0000);

    // Misaligned LH: error response right after acceptance, no DMEM access
    send(1'b0, 3'b001, 32'h8000_0001, 32'h0);
    wait_rsp("lh_mis", 0);
    check("lh_mis_rd", 32'(if0.dmem_rd), 32'h0);
    check("lh_mis_we", 32'(if0.dmem_we), 32'h0);
    finish_rsp("lh_mis", 32'h0, 1'b1);

    // Illegal store funct3
    send(1'b1, 3'b011, 32'h8000_0018, 32'h5555_5555);
    wait_rsp("st_ill", 0);
    check("st_ill_we", 32'(if0.dmem_we), 32'h0);
    finish_rsp("st_ill", 32'h0, 1'b1);
    check("st_ill_ram", ram[6], 32'h0);

    // ID register read at READ_LATENCY=1
    send(1'b0, 3'b010, 32'h0010_0000, 32'h0);
    wait_rsp("lw_id", 2);
    finish_rsp("lw_id", 32'h1329_6397, 1'b0);

    // Same read on the READ_LATENCY=3 instance
    begin
      int n = 0;
      check("rl3_req_ready", 32'(if1.req_ready), 32'h1);
      if1.req_valid = 1'b1; if1.req_we = 1'b0; if1.req_funct3 = 3'b010;
      if1.req_addr = 32'h0010_0000;
      @(posedge clk); #1;
      if1.req_valid = 1'b0;
      while (!if1.rsp_valid && n < 20) begin
        @(posedge clk); #1;
        n++;
      end
      check("rl3_latency", 32'(n), 32'd4);
      check("rl3_rdata", if1.rsp_rdata, 32'h1329_6397);
      if1.rsp_ready = 1'b1;
      @(posedge clk); #1;
      if1.rsp_ready = 1'b0;
      check("rl3_back_idle", 32'(if1.req_ready), 32'h1);
    end

    // Response stalled by rsp_ready low for 5 cycles
    send(1'b0, 3'b010, 32'h8000_0010, 32'h0);
    wait_rsp("stall", 2);
    for (int i = 0; i < 5; i++) begin
      check("stall_valid", 32'(if0.rsp_valid), 32'h1);
      check("stall_rdata", if0.rsp_rdata, 32'hFEDC_A598);
      check("stall_req_ready", 32'(if0.req_ready), 32'h0);
      @(posedge clk); #1;
    end
    finish_rsp("stall", 32'hFEDC_A598, 1'b0);

    // Reset during the ACCESS cycle of an SW
    send(1'b1, 3'b010, 32'h8000_0020, 32'h1122_3344);
    check("rst_sw_we_pre", 32'(if0.dmem_we), 32'hF);
    #2 rstn = 1'b0;
    #1;
    check("rst_sw_we_async", 32'(if0.dmem_we), 32'h0);
    @(posedge clk); #1;
    check("rst_sw_ram", ram[8], 32'h0);
    check("rst_sw_rsp_valid", 32'(if0.rsp_valid), 32'h0);
    rstn = 1'b1;
    @(posedge clk); #1;
    check("rst_sw_req_ready", 32'(if0.req_ready), 32'h1);
    check("rst_sw_rsp_after", 32'(if0.rsp_valid), 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
